// File: rtl/ex_flag_stage.sv
// Execute-stage output register with NZCV flag register and branch resolution.
// Define EX_COND_EVAL_EN to include condition evaluation; otherwise branch_taken is tied to 0.
module ex_flag_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] alu_result,
  input  logic        alu_zero,
  input  logic        alu_overflow,
  input  logic        alu_carry_out,
  input  logic        alu_negative,
  input  logic        set_flags,
  input  logic        is_bcond,
  input  logic        is_cbz,
  input  logic [3:0]  cond,
  input  logic [4:0]  dest_reg,
  input  logic        reg_write,
  input  logic        flush,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [63:0] out_result,
  output logic [4:0]  out_dest,
  output logic        out_reg_write,
  output logic [3:0]  flags,
  output logic        branch_taken
);

  logic accept;
  logic taken_d;
  logic taken_q;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready && !flush;

`ifdef EX_COND_EVAL_EN
  logic flag_n, flag_z, flag_c, flag_v;
  logic bcond_taken;

  // B.cond sees the flags as they stood before this instruction's own update.
  assign {flag_n, flag_z, flag_c, flag_v} = flags;

  always_comb begin
    bcond_taken = 1'b0;
    case (cond)
      4'd0:    bcond_taken = flag_z;
      4'd1:    bcond_taken = !flag_z;
      4'd2:    bcond_taken = flag_c;
      4'd3:    bcond_taken = !flag_c;
      4'd4:    bcond_taken = flag_n;
      4'd5:    bcond_taken = !flag_n;
      4'd6:    bcond_taken = flag_v;
      4'd7:    bcond_taken = !flag_v;
      4'd8:    bcond_taken = flag_c && !flag_z;
      4'd9:    bcond_taken = !flag_c || flag_z;
      4'd10:   bcond_taken = (flag_n == flag_v);
      4'd11:   bcond_taken = (flag_n != flag_v);
      4'd12:   bcond_taken = !flag_z && (flag_n == flag_v);
      4'd13:   bcond_taken = flag_z || (flag_n != flag_v);
      default: bcond_taken = 1'b1;
    endcase
  end

  // CBZ wins when both qualifiers are (illegally) asserted.
  always_comb begin
    taken_d = 1'b0;
    if (is_cbz)
      taken_d = alu_zero ^ cond[0];
    else if (is_bcond)
      taken_d = bcond_taken;
  end
`else
  logic unused_cond_inputs;
  assign unused_cond_inputs = ^{cond, is_bcond, is_cbz};
  assign taken_d = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid     <= 1'b0;
      out_result    <= 64'd0;
      out_dest      <= 5'd0;
      out_reg_write <= 1'b0;
      taken_q       <= 1'b0;
      flags         <= 4'b0000;
    end else begin
      if (flush) begin
        out_valid <= 1'b0;
      end else if (accept) begin
        out_valid     <= 1'b1;
        out_result    <= alu_result;
        out_dest      <= dest_reg;
        out_reg_write <= reg_write;
        taken_q       <= taken_d;
        if (set_flags)
          flags <= {alu_negative, alu_zero, alu_carry_out, alu_overflow};
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign branch_taken = taken_q && out_valid;

endmodule

// File: tb/tb_ex_flag_stage.sv
// Directed bench for ex_flag_stage; branch expectations follow EX_COND_EVAL_EN.
module tb_ex_flag_stage;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] alu_result;
  logic        alu_zero, alu_overflow, alu_carry_out, alu_negative;
  logic        set_flags, is_bcond, is_cbz;
  logic [3:0]  cond;
  logic [4:0]  dest_reg;
  logic        reg_write, flush, out_ready;
  logic        out_valid;
  logic [63:0] out_result;
  logic [4:0]  out_dest;
  logic        out_reg_write;
  logic [3:0]  flags;
  logic        branch_taken;

  int checks = 0;
  int errors = 0;

`ifdef EX_COND_EVAL_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif

  ex_flag_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
    .alu_carry_out(alu_carry_out), .alu_negative(alu_negative),
    .set_flags(set_flags), .is_bcond(is_bcond), .is_cbz(is_cbz), .cond(cond),
    .dest_reg(dest_reg), .reg_write(reg_write), .flush(flush),
    .out_ready(out_ready), .out_valid(out_valid), .out_result(out_result),
    .out_dest(out_dest), .out_reg_write(out_reg_write), .flags(flags),
    .branch_taken(branch_taken)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [63:0] res, input logic [3:0] nzcv,
                       input logic sf, input logic bc, input logic cb, input logic [3:0] cc,
                       input logic [4:0] dst);
    in_valid      = v;
    alu_result    = res;
    alu_negative  = nzcv[3];
    alu_zero      = nzcv[2];
    alu_carry_out = nzcv[1];
    alu_overflow  = nzcv[0];
    set_flags     = sf;
    is_bcond      = bc;
    is_cbz        = cb;
    cond          = cc;
    dest_reg      = dst;
    reg_write     = 1'b1;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; out_ready = 1'b1;
    drive(1'b0, 64'd0, 4'b0000, 1'b0, 1'b0, 1'b0, 4'd0, 5'd0);
    reg_write = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_result", out_result, 64'd0);
    check("rst_flags", flags, 4'b0000);
    check("rst_branch", branch_taken, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    reset = 1'b0;

    // Basic accept with flags update.
    drive(1'b1, 64'h5, 4'b0010, 1'b1, 1'b0, 1'b0, 4'd0, 5'd3);
    tick();
    check("acc_out_valid", out_valid, 1'b1);
    check("acc_out_result", out_result, 64'h5);
    check("acc_out_dest", out_dest, 5'd3);
    check("acc_reg_write", out_reg_write, 1'b1);
    check("acc_flags", flags, 4'b0010);

    // SUBS producing zero, then B.EQ / B.NE.
    drive(1'b1, 64'h0, 4'b0100, 1'b1, 1'b0, 1'b0, 4'd0, 5'd4);
    tick();
    check("subs_flags", flags, 4'b0100);
    drive(1'b1, 64'h10, 4'b0000, 1'b0, 1'b1, 1'b0, 4'd0, 5'd0);
    tick();
    check("beq_taken", branch_taken, EN);
    check("beq_flags", flags, 4'b0100);
    drive(1'b1, 64'h11, 4'b0000, 1'b0, 1'b1, 1'b0, 4'd1, 5'd0);
    tick();
    check("bne_taken", branch_taken, 1'b0);

    // CBZ / CBNZ and illegal both-qualifier case (resolved as CBNZ; B.NE would say 0).
    drive(1'b1, 64'h0, 4'b0100, 1'b0, 1'b0, 1'b1, 4'd0, 5'd0);
    tick();
    check("cbz_taken", branch_taken, EN);
    drive(1'b1, 64'h7, 4'b0000, 1'b0, 1'b0, 1'b1, 4'd1, 5'd0);
    tick();
    check("cbnz_taken", branch_taken, EN);
    drive(1'b1, 64'h7, 4'b0000, 1'b0, 1'b1, 1'b1, 4'd1, 5'd0);
    tick();
    check("both_as_cbz", branch_taken, EN);
    drive(1'b1, 64'h7, 4'b0000, 1'b0, 1'b0, 1'b0, 4'd14, 5'd0);
    tick();
    check("no_branch", branch_taken, 1'b0);

    // Flags N=1 V=1, then signed conditions.
    drive(1'b1, 64'h8000_0000_0000_0000, 4'b1001, 1'b1, 1'b0, 1'b0, 4'd0, 5'd1);
    tick();
    check("nv_flags", flags, 4'b1001);
    drive(1'b1, 64'h1, 4'b0000, 1'b0, 1'b1, 1'b0, 4'd10, 5'd0);
    tick();
    check("bge_taken", branch_taken, EN);
    cond = 4'd12; tick();
    check("bgt_taken", branch_taken, EN);
    cond = 4'd11; tick();
    check("blt_taken", branch_taken, 1'b0);
    cond = 4'd8; tick();
    check("bhi_taken", branch_taken, 1'b0);
    cond = 4'd9; tick();
    check("bls_taken", branch_taken, EN);
    cond = 4'd15; tick();
    check("bal_taken", branch_taken, EN);

    // B.EQ sees pre-update flags even when the same instruction sets Z.
    drive(1'b1, 64'h0, 4'b0100, 1'b1, 1'b1, 1'b0, 4'd0, 5'd0);
    tick();
    check("beq_old_flags", branch_taken, 1'b0);
    check("beq_new_flags", flags, 4'b0100);
    drive(1'b1, 64'h0, 4'b0000, 1'b0, 1'b1, 1'b0, 4'd0, 5'd0);
    tick();
    check("beq_after", branch_taken, EN);

    // Backpressure: hold payload A for 3 cycles, then B with no bubble.
    drive(1'b1, 64'hAAAA, 4'b0000, 1'b0, 1'b0, 1'b0, 4'd0, 5'd7);
    tick();
    check("bp_load_a", out_result, 64'hAAAA);
    drive(1'b1, 64'hBBBB, 4'b1010, 1'b1, 1'b0, 1'b0, 4'd0, 5'd9);
    out_ready = 1'b0;
    #1;
    check("bp_in_ready_low", in_ready, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_hold_valid", out_valid, 1'b1);
      check("bp_hold_result", out_result, 64'hAAAA);
      check("bp_hold_dest", out_dest, 5'd7);
      check("bp_hold_flags", flags, 4'b0100);
      check("bp_hold_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    #1;
    check("bp_in_ready_high", in_ready, 1'b1);
    tick();
    check("bp_b_valid", out_valid, 1'b1);
    check("bp_b_result", out_result, 64'hBBBB);
    check("bp_b_flags", flags, 4'b1010);
    in_valid = 1'b0;
    tick();
    check("drain_valid", out_valid, 1'b0);

    // Flush on an offer: nothing accepted, flags kept.
    drive(1'b1, 64'hCCCC, 4'b1000, 1'b1, 1'b0, 1'b0, 4'd0, 5'd2);
    flush = 1'b1;
    tick();
    check("flush_valid", out_valid, 1'b0);
    check("flush_flags", flags, 4'b1010);
    // Flush kills a stalled entry.
    flush = 1'b0;
    drive(1'b1, 64'hDDDD, 4'b0000, 1'b0, 1'b0, 1'b0, 4'd0, 5'd2);
    tick();
    check("pre_flush_valid", out_valid, 1'b1);
    out_ready = 1'b0; flush = 1'b1;
    tick();
    check("flush_stall_valid", out_valid, 1'b0);
    flush = 1'b0; out_ready = 1'b1;

    // Asynchronous reset mid-transfer.
    drive(1'b1, 64'hEEEE, 4'b0110, 1'b1, 1'b0, 1'b0, 4'd0, 5'd5);
    tick();
    check("pre_rst_valid", out_valid, 1'b1);
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("async_rst_valid", out_valid, 1'b0);
    check("async_rst_flags", flags, 4'b0000);
    check("async_rst_result", out_result, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    drive(1'b1, 64'h1234, 4'b0000, 1'b0, 1'b0, 1'b0, 4'd0, 5'd6);
    tick();
    check("post_rst_valid", out_valid, 1'b1);
    check("post_rst_result", out_result, 64'h1234);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_flag_stage.md
EX_FLAG_STAGE -- requirements
Module: ex_flag_stage

Interface
REQ-001 SHALL use one clock and an asynchronous, active-high reset.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  upstream ALU result valid this cycle.
REQ-005 in_ready  output  1  stage can accept.
REQ-006 alu_result  input  64  ALU result bus.
REQ-007 alu_zero, alu_overflow, alu_carry_out, alu_negative  input  1 each  ALU flag outputs.
REQ-008 set_flags  input  1  instruction updates the NZCV register.
REQ-009 is_bcond, is_cbz  input  1 each  conditional-branch and compare-and-branch qualifiers; both high together is illegal.
REQ-010 cond  input  4  condition code; for CBZ, cond[0]=1 selects CBNZ.
REQ-011 dest_reg  input  5 and reg_write  input  1  writeback tag, passed through.
REQ-012 flush  input  1  kill the registered entry and any offer this cycle.
REQ-013 out_ready  input  1  downstream accepts.
REQ-014 out_valid  output  1, out_result  output  64, out_dest  output  5, out_reg_write  output  1  registered payload.
REQ-015 flags  output  4  architectural {N,Z,C,V} register.
REQ-016 branch_taken  output  1  registered, qualified by out_valid.

Function
REQ-017 SHALL drive in_ready = !out_valid || out_ready (combinational; single-entry register).
REQ-018 SHALL accept on the rising edge when in_valid && in_ready && !flush; latency 1 cycle, input to out_valid.
REQ-019 SHALL load out_result, out_dest, out_reg_write and branch_taken on accept; out_valid=1.
REQ-020 SHALL clear out_valid on out_ready without accept; on simultaneous drain and accept, out_valid stays 1 with new payload (full throughput).
REQ-021 SHALL hold the payload stable while out_valid && !out_ready.
REQ-022 SHALL write flags <= {alu_negative, alu_zero, alu_carry_out, alu_overflow} on accept with set_flags=1; otherwise hold.
REQ-023 SHALL evaluate B.cond against the flag register value before this cycle's update: 0 EQ Z, 1 NE !Z, 2 CS C, 3 CC !C, 4 MI N, 5 PL !N, 6 VS V, 7 VC !V, 8 HI C&!Z, 9 LS !C|Z, 10 GE N==V, 11 LT N!=V, 12 GT !Z&(N==V), 13 LE Z|(N!=V), 14 and 15 always.
REQ-024 SHALL compute CBZ taken = alu_zero XOR cond[0], independent of the flag register.
REQ-025 SHALL set branch_taken=0 when neither is_bcond nor is_cbz.
REQ-026 flush: out_valid <= 0 next edge regardless of out_ready; input not accepted; flags not updated; flush overrides a simultaneous accept.
REQ-027 Illegal is_bcond && is_cbz SHALL resolve as is_cbz.

Reset
REQ-028 On reset, asynchronously: out_valid=0, out_result=0, out_dest=0, out_reg_write=0, branch_taken=0, flags=4'b0000.
REQ-029 Reset mid-transfer SHALL discard the entry; first accept earliest on the first edge after reset deassertion.

Configuration
REQ-030 Macro EX_COND_EVAL_EN: defined -> REQ-023/024 logic present; undefined -> branch_taken constant 0, cond/is_bcond/is_cbz ignored, flags register and handshake unchanged.

Verification
REQ-031 Reset, then accept result 64'h5, set_flags=1, zero=0, carry=1 -> next cycle out_valid=1, out_result=5, flags=4'b0010.
REQ-032 SUBS result 0 (zero=1, set_flags=1), next B.cond cond=0 -> branch_taken=1; same sequence with cond=1 -> 0.
REQ-033 out_ready=0 for 3 cycles with out_valid=1, in_valid=1 -> in_ready=0, payload unchanged, flags unchanged; then out_ready=1 -> new payload next cycle, no bubble.
REQ-034 flush with in_valid=1, set_flags=1, negative=1 -> out_valid=0 next cycle, flags unchanged.
REQ-035 CBNZ (is_cbz=1, cond[0]=1) with alu_zero=0 -> branch_taken=1; flags=4'b1001 (N=V) with cond=10 GE -> 1, cond=12 GT with Z=0 -> 1.
REQ-036 EX_COND_EVAL_EN undefined, rerun REQ-032 -> branch_taken=0, flags still 4'b0100 after SUBS.
